// File: rtl/sample_framer.sv
// Frame capture buffer: records N samples on every channel, then streams the
// frame out channel by channel over a valid/ready link, repeating for RUNS frames.
module sample_framer #(
  parameter int SINK_WIDTH = 14,
  parameter int FFT_DEPTH  = 11,
  parameter int CHANNELS   = 2,
  parameter int RUNS       = 3,
  localparam int CHAN_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [CHANNELS*SINK_WIDTH-1:0] sink,
  input  logic                           sink_valid,
  input  logic                           start,
  input  logic                           abort,
  output logic [SINK_WIDTH-1:0]          src_data,
  output logic [CHAN_W-1:0]              src_chan,
  output logic [7:0]                     src_run,
  output logic                           src_valid,
  input  logic                           src_ready,
  output logic                           src_sop,
  output logic                           src_eop,
  output logic                           busy,
  output logic                           done,
  output logic                           overflow
);

  localparam int N = 1 << FFT_DEPTH;
  localparam logic [FFT_DEPTH-1:0] LAST_IDX  = FFT_DEPTH'(N - 1);
  localparam logic [CHAN_W-1:0]    LAST_CHAN = CHAN_W'(CHANNELS - 1);
  localparam logic [7:0]           LAST_RUN  = 8'(RUNS - 1);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, FINISH} state_t;

  state_t r_state;
  state_t w_nextState;

  logic [FFT_DEPTH-1:0]  r_index;
  logic [FFT_DEPTH-1:0]  r_rdIdx;
  logic [CHAN_W-1:0]     r_rdChan;
  logic [7:0]            r_run;
  logic                  r_overflow;
  logic                  r_loadDone;

  logic [SINK_WIDTH-1:0] r_mem [CHANNELS][N];

  logic [SINK_WIDTH-1:0] r_srcData;
  logic [CHAN_W-1:0]     r_srcChan;
  logic [7:0]            r_srcRun;
  logic                  r_srcValid;
  logic                  r_srcSop;
  logic                  r_srcEop;
  logic                  r_srcLast;

  logic w_accept;
  logic w_writeEn;
  logic w_lastWrite;
  logic w_load;
  logic w_lastXfer;

  assign w_accept    = (r_state == IDLE) && start && !abort;
  assign w_writeEn   = (r_state == FILL) && sink_valid;
  assign w_lastWrite = w_writeEn && (r_index == LAST_IDX);
  // The output register doubles as the RAM read register, so a new word is
  // fetched whenever the slot is empty or is being consumed this cycle.
  assign w_load      = (r_state == DRAIN) && !r_loadDone && (!r_srcValid || src_ready);
  assign w_lastXfer  = (r_state == DRAIN) && r_srcValid && src_ready && r_srcLast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (abort) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (start) w_nextState = FILL;
        FILL:    if (w_lastWrite) w_nextState = DRAIN;
        DRAIN:   if (w_lastXfer) w_nextState = (r_run < LAST_RUN) ? FILL : FINISH;
        FINISH:  w_nextState = IDLE;
        default: w_nextState = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_index    <= '0;
      r_run      <= '0;
      r_overflow <= 1'b0;
    end else if (abort) begin
      r_index <= '0;
    end else begin
      if (w_accept) begin
        r_index    <= '0;
        r_run      <= '0;
        r_overflow <= 1'b0;
      end
      if (w_writeEn) begin
        r_index <= w_lastWrite ? '0 : r_index + 1'b1;
      end
      if ((r_state == DRAIN) && sink_valid) begin
        r_overflow <= 1'b1;
      end
      if (w_lastXfer && (r_run < LAST_RUN)) begin
        r_run <= r_run + 8'd1;
      end
    end
  end

  // Read pointer walks channel-major: all indices of channel 0, then channel 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdIdx    <= '0;
      r_rdChan   <= '0;
      r_loadDone <= 1'b0;
    end else if (w_lastWrite && !abort) begin
      r_rdIdx    <= '0;
      r_rdChan   <= '0;
      r_loadDone <= 1'b0;
    end else if (w_load) begin
      if (r_rdIdx == LAST_IDX) begin
        r_rdIdx <= '0;
        if (r_rdChan == LAST_CHAN) begin
          r_loadDone <= 1'b1;
        end else begin
          r_rdChan <= r_rdChan + 1'b1;
        end
      end else begin
        r_rdIdx <= r_rdIdx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_writeEn) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_mem[c][r_index] <= sink[c*SINK_WIDTH +: SINK_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_srcData  <= '0;
      r_srcChan  <= '0;
      r_srcRun   <= '0;
      r_srcValid <= 1'b0;
      r_srcSop   <= 1'b0;
      r_srcEop   <= 1'b0;
      r_srcLast  <= 1'b0;
    end else if (abort) begin
      r_srcValid <= 1'b0;
      r_srcSop   <= 1'b0;
      r_srcEop   <= 1'b0;
      r_srcLast  <= 1'b0;
    end else if (w_load) begin
      r_srcValid <= 1'b1;
      r_srcData  <= r_mem[r_rdChan][r_rdIdx];
      r_srcChan  <= r_rdChan;
      r_srcRun   <= r_run;
      r_srcSop   <= (r_rdIdx == '0);
      r_srcEop   <= (r_rdIdx == LAST_IDX);
      r_srcLast  <= (r_rdIdx == LAST_IDX) && (r_rdChan == LAST_CHAN);
    end else if (src_ready) begin
      r_srcValid <= 1'b0;
      r_srcLast  <= 1'b0;
    end
  end

  assign src_data  = r_srcData;
  assign src_chan  = r_srcChan;
  assign src_run   = r_srcRun;
  assign src_valid = r_srcValid;
  assign src_sop   = r_srcSop;
  assign src_eop   = r_srcEop;
  assign busy      = (r_state == FILL) || (r_state == DRAIN);
  assign done      = (r_state == FINISH);
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_sample_framer.sv
// Bench for sample_framer: a single-run and a three-run instance share stimulus
// and are both checked every cycle against a frame-level reference model.
module tb_sample_framer;

  localparam int W       = 14;
  localparam int DEPTH   = 3;
  localparam int N       = 8;
  localparam int WORDS   = 16;
  localparam int LOG_MAX = 256;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2*W-1:0]   sink;
  logic             sink_valid;
  logic             abort;
  logic             src_ready = 1'b1;
  logic             readyMode = 1'b0;
  logic [1:0]       startVec;
  logic [1:0][W-1:0] srcData;
  logic [1:0]       srcChan;
  logic [1:0][7:0]  srcRun;
  logic [1:0]       srcValid, srcSop, srcEop, busy, done, overflow;

  int checks   = 0;
  int failures = 0;

  typedef enum int {M_IDLE, M_FILL, M_DRAIN, M_FINISH} mphase_t;

  mphase_t     mPhase [2];
  int          mIdx [2];
  int          mRun [2];
  int          mAge [2];
  logic        mOvf [2];
  int          expPtr [2];
  logic [W-1:0] frameBuf [2][2][N];
  logic [24:0] expWords [2][WORDS];
  logic [24:0] logWords [2][LOG_MAX];
  int          logCnt [2] = '{0, 0};
  int          doneCnt [2] = '{0, 0};

  always #5 clk = ~clk;

  sample_framer #(.SINK_WIDTH(W), .FFT_DEPTH(DEPTH), .CHANNELS(2), .RUNS(1)) dutSingle (
    .clk(clk), .rst_n(rst_n), .sink(sink), .sink_valid(sink_valid),
    .start(startVec[0]), .abort(abort),
    .src_data(srcData[0]), .src_chan(srcChan[0]), .src_run(srcRun[0]),
    .src_valid(srcValid[0]), .src_ready(src_ready), .src_sop(srcSop[0]), .src_eop(srcEop[0]),
    .busy(busy[0]), .done(done[0]), .overflow(overflow[0])
  );

  sample_framer #(.SINK_WIDTH(W), .FFT_DEPTH(DEPTH), .CHANNELS(2), .RUNS(3)) dutMulti (
    .clk(clk), .rst_n(rst_n), .sink(sink), .sink_valid(sink_valid),
    .start(startVec[1]), .abort(abort),
    .src_data(srcData[1]), .src_chan(srcChan[1]), .src_run(srcRun[1]),
    .src_valid(srcValid[1]), .src_ready(src_ready), .src_sop(srcSop[1]), .src_eop(srcEop[1]),
    .busy(busy[1]), .done(done[1]), .overflow(overflow[1])
  );

  // Sink side of the stream: always ready, or a fair coin per cycle.
  always @(posedge clk) begin
    #1;
    src_ready = readyMode ? (($urandom % 2) == 1) : 1'b1;
  end

  function automatic logic [24:0] packWord(input logic [W-1:0] data, input logic chan,
                                           input logic [7:0] run, input logic sop, input logic eop);
    return {data, chan, run, sop, eop};
  endfunction

  function automatic logic [28:0] allOutputs(input int d);
    return {srcData[d], srcChan[d], srcRun[d], srcValid[d], srcSop[d], srcEop[d],
            busy[d], done[d], overflow[d]};
  endfunction

  function automatic int runsOf(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Frame-level reference: collect N strobes, then expect the frame channel by
  // channel; checks outputs seen now, then advances to what the next edge does.
  task automatic modelCycle(input int d);
    logic [24:0] got;
    got = packWord(srcData[d], srcChan[d], srcRun[d], srcSop[d], srcEop[d]);
    if (!rst_n) begin
      checkOutput($sformatf("dut%0d outputs in reset", d), 64'(allOutputs(d)), 64'd0);
      mPhase[d] = M_IDLE;
      mIdx[d]   = 0;
      mRun[d]   = 0;
      mOvf[d]   = 1'b0;
      mAge[d]   = 0;
      expPtr[d] = 0;
      return;
    end
    checkOutput($sformatf("dut%0d busy", d), 64'(busy[d]),
                64'((mPhase[d] == M_FILL) || (mPhase[d] == M_DRAIN)));
    checkOutput($sformatf("dut%0d done", d), 64'(done[d]), 64'(mPhase[d] == M_FINISH));
    checkOutput($sformatf("dut%0d overflow", d), 64'(overflow[d]), 64'(mOvf[d]));
    if (mPhase[d] != M_DRAIN) begin
      checkOutput($sformatf("dut%0d valid outside drain", d), 64'(srcValid[d]), 64'd0);
    end else if (srcValid[d]) begin
      checkOutput($sformatf("dut%0d word %0d", d, expPtr[d]), 64'(got), 64'(expWords[d][expPtr[d]]));
    end else if (mAge[d] >= 2) begin
      checkOutput($sformatf("dut%0d valid gap at word %0d", d, expPtr[d]), 64'(srcValid[d]), 64'd1);
    end

    if (done[d]) doneCnt[d]++;
    if ((mPhase[d] == M_DRAIN) && srcValid[d] && src_ready) begin
      if (logCnt[d] < LOG_MAX) logWords[d][logCnt[d]] = got;
      logCnt[d]++;
      expPtr[d]++;
    end

    if (abort) begin
      mPhase[d] = M_IDLE;
    end else begin
      case (mPhase[d])
        M_IDLE: begin
          if (startVec[d]) begin
            mPhase[d] = M_FILL;
            mRun[d]   = 0;
            mIdx[d]   = 0;
            mOvf[d]   = 1'b0;
          end
        end
        M_FILL: begin
          if (sink_valid) begin
            for (int c = 0; c < 2; c++) frameBuf[d][c][mIdx[d]] = sink[c*W +: W];
            mIdx[d]++;
            if (mIdx[d] == N) begin
              for (int c = 0; c < 2; c++)
                for (int i = 0; i < N; i++)
                  expWords[d][c*N+i] = packWord(frameBuf[d][c][i], 1'(c), 8'(mRun[d]), i == 0, i == N-1);
              expPtr[d] = 0;
              mAge[d]   = 0;
              mPhase[d] = M_DRAIN;
            end
          end
        end
        M_DRAIN: begin
          if (sink_valid) mOvf[d] = 1'b1;
          if (expPtr[d] == WORDS) begin
            if (mRun[d] < runsOf(d) - 1) begin
              mRun[d]++;
              mIdx[d]   = 0;
              mPhase[d] = M_FILL;
            end else begin
              mPhase[d] = M_FINISH;
            end
          end else begin
            mAge[d]++;
          end
        end
        default: mPhase[d] = M_IDLE;
      endcase
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) modelCycle(d);
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic sv, input logic [W-1:0] s0, input logic [W-1:0] s1,
                               input logic [1:0] st, input logic ab);
    sink_valid = sv;
    sink       = {s1, s0};
    startVec   = st;
    abort      = ab;
    @(posedge clk);
    #1;
    sink_valid = 1'b0;
    startVec   = 2'b00;
    abort      = 1'b0;
  endtask

  task automatic fillFrame(input logic [W-1:0] a, input logic [W-1:0] b, input int count, input int gap);
    for (int k = 0; k < count; k++) begin
      applyStimulus(1'b1, a + W'(k), b - W'(k), 2'b00, 1'b0);
      repeat (gap) applyStimulus(1'b0, '0, '0, 2'b00, 1'b0);
    end
  endtask

  task automatic waitDone(input int d, input int bound, input string tag);
    int base;
    int n;
    base = doneCnt[d];
    n = 0;
    while ((doneCnt[d] == base) && (n < bound)) begin
      @(negedge clk);
      #1;
      n++;
    end
    repeat (3) sync();
    checkOutput({tag, " done pulses"}, 64'(doneCnt[d] - base), 64'd1);
  endtask

  task automatic checkFrame(input int d, input int base, input logic [W-1:0] a,
                            input logic [W-1:0] b, input string tag);
    logic [W-1:0] v;
    checkOutput({tag, " word count"}, 64'(logCnt[d] - base), 64'(WORDS));
    if ((logCnt[d] - base >= WORDS) && (base + WORDS <= LOG_MAX)) begin
      for (int j = 0; j < WORDS; j++) begin
        v = (j < N) ? a + W'(j) : b - W'(j - N);
        checkOutput($sformatf("%s literal word %0d", tag, j), 64'(logWords[d][base+j]),
                    64'(packWord(v, 1'(j / N), 8'd0, (j % N) == 0, (j % N) == N-1)));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int dbase;
    int n;
    int cnt;
    logic [24:0] w;

    sink = '0; sink_valid = 1'b0; abort = 1'b0; startVec = 2'b00; rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset dut0 before clock", 64'(allOutputs(0)), 64'd0);
    checkOutput("async reset dut1 before clock", 64'(allOutputs(1)), 64'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    sync();

    $display("[TB] basic capture");
    base = logCnt[0];
    applyStimulus(1'b0, '0, '0, 2'b01, 1'b0);
    fillFrame(W'(0), W'(-1), N, 1);
    waitDone(0, 200, "basic");
    checkFrame(0, base, W'(0), W'(-1), "basic");
    checkOutput("basic overflow", 64'(overflow[0]), 64'd0);

    $display("[TB] backpressure");
    readyMode = 1'b1;
    base = logCnt[0];
    applyStimulus(1'b0, '0, '0, 2'b01, 1'b0);
    fillFrame(W'(0), W'(-1), N, 1);
    waitDone(0, 300, "backpressure");
    checkFrame(0, base, W'(0), W'(-1), "backpressure");
    readyMode = 1'b0;
    repeat (2) sync();

    $display("[TB] multi-run");
    base  = logCnt[1];
    dbase = doneCnt[1];
    applyStimulus(1'b0, '0, '0, 2'b10, 1'b0);
    cnt = 0;
    while ((doneCnt[1] == dbase) && (cnt < 300)) begin
      applyStimulus(1'b1, W'(cnt), ~W'(cnt), 2'b00, 1'b0);
      applyStimulus(1'b0, '0, '0, 2'b00, 1'b0);
      applyStimulus(1'b0, '0, '0, 2'b00, 1'b0);
      cnt++;
    end
    repeat (2) sync();
    checkOutput("multirun done pulses", 64'(doneCnt[1] - dbase), 64'd1);
    checkOutput("multirun word count", 64'(logCnt[1] - base), 64'd48);
    checkOutput("multirun overflow", 64'(overflow[1]), 64'd1);
    checkOutput("multirun busy after done", 64'(busy[1]), 64'd0);
    if ((logCnt[1] - base >= 48) && (base + 48 <= LOG_MAX)) begin
      for (int j = 0; j < 48; j++) begin
        w = logWords[1][base+j];
        checkOutput($sformatf("multirun chan/run word %0d", j), 64'({w[10], w[9:2]}),
                    64'({1'((j / N) % 2), 8'(j / WORDS)}));
        if (j < N)
          checkOutput($sformatf("multirun first frame word %0d", j), 64'(w),
                      64'(packWord(W'(j), 1'b0, 8'd0, j == 0, j == N-1)));
      end
    end

    $display("[TB] abort");
    dbase = doneCnt[0];
    applyStimulus(1'b0, '0, '0, 2'b01, 1'b0);
    fillFrame(W'(40), W'(-40), 4, 1);
    applyStimulus(1'b0, '0, '0, 2'b00, 1'b1);
    checkOutput("abort busy next cycle", 64'(busy[0]), 64'd0);
    checkOutput("abort valid next cycle", 64'(srcValid[0]), 64'd0);
    repeat (5) sync();
    checkOutput("abort no done", 64'(doneCnt[0] - dbase), 64'd0);
    base = logCnt[0];
    applyStimulus(1'b0, '0, '0, 2'b01, 1'b0);
    fillFrame(W'(100), W'(-100), N, 1);
    waitDone(0, 200, "after abort");
    checkFrame(0, base, W'(100), W'(-100), "after abort");

    $display("[TB] async reset mid-drain");
    base = logCnt[0];
    applyStimulus(1'b0, '0, '0, 2'b01, 1'b0);
    fillFrame(W'(200), W'(-200), N, 1);
    n = 0;
    while ((logCnt[0] - base < 5) && (n < 100)) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("reset reached word 5", 64'(logCnt[0] - base >= 5), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset mid-drain dut0 outputs", 64'(allOutputs(0)), 64'd0);
    checkOutput("reset mid-drain dut1 outputs", 64'(allOutputs(1)), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    sync();
    repeat (4) applyStimulus(1'b0, '0, '0, 2'b00, 1'b0);
    checkOutput("after reset idle busy", 64'(busy[0]), 64'd0);
    checkOutput("after reset idle valid", 64'(srcValid[0]), 64'd0);
    base = logCnt[0];
    applyStimulus(1'b0, '0, '0, 2'b01, 1'b0);
    fillFrame(W'(50), W'(-50), N, 1);
    waitDone(0, 200, "after reset");
    checkFrame(0, base, W'(50), W'(-50), "after reset");

    $display("[TB] ignored controls");
    repeat (3) applyStimulus(1'b1, W'(16'h1234), W'(16'h2345), 2'b00, 1'b0);
    checkOutput("idle sink busy", 64'(busy[0]), 64'd0);
    checkOutput("idle sink overflow", 64'(overflow[0]), 64'd0);
    base = logCnt[0];
    applyStimulus(1'b0, '0, '0, 2'b01, 1'b0);
    fillFrame(W'(0), W'(-1), N, 1);
    n = 0;
    while ((logCnt[0] - base < 3) && (n < 100)) begin
      @(negedge clk);
      #1;
      n++;
    end
    sync();
    applyStimulus(1'b0, '0, '0, 2'b01, 1'b0);
    waitDone(0, 200, "ignored start");
    checkFrame(0, base, W'(0), W'(-1), "ignored start");
    repeat (30) sync();
    checkOutput("ignored start no restart", 64'(busy[0]), 64'd0);
    checkOutput("ignored start word total", 64'(logCnt[0] - base), 64'(WORDS));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
